// File: rtl/mario_input_pkg.sv
// mario_input_pkg
// Shared definitions for the player-input front end:
//   - PS/2 scancodes and the key-state slot each one loads
//   - joystick word bit positions
//   - bit positions inside the two active-low switch bytes
//   - the merged request record (ctrl_t) and the coin FSM state type
//   - key_match(): scancode -> one-hot key-state slot
package mario_input_pkg;

  // Scancodes, {extended, code}. Arrow keys match on the low byte only.
  localparam logic [8:0] SC_LEFT1    = 9'h06B;
  localparam logic [8:0] SC_RIGHT1   = 9'h074;
  localparam logic [8:0] SC_FIRE1_A  = 9'h029;
  localparam logic [8:0] SC_FIRE1_B  = 9'h014;
  localparam logic [8:0] SC_START1_A = 9'h005;
  localparam logic [8:0] SC_START1_B = 9'h016;
  localparam logic [8:0] SC_START2_A = 9'h006;
  localparam logic [8:0] SC_START2_B = 9'h01E;
  localparam logic [8:0] SC_COIN_A   = 9'h02E;
  localparam logic [8:0] SC_COIN_B   = 9'h036;
  localparam logic [8:0] SC_LEFT2    = 9'h023;
  localparam logic [8:0] SC_RIGHT2   = 9'h034;
  localparam logic [8:0] SC_FIRE2    = 9'h01C;
  localparam logic [8:0] SC_TEST     = 9'h02C;

  // Key-state slots; a function with two codes owns two slots.
  localparam int KEY_N      = 14;
  localparam int K_LEFT1    = 0;
  localparam int K_RIGHT1   = 1;
  localparam int K_FIRE1_A  = 2;
  localparam int K_FIRE1_B  = 3;
  localparam int K_START1_A = 4;
  localparam int K_START1_B = 5;
  localparam int K_START2_A = 6;
  localparam int K_START2_B = 7;
  localparam int K_COIN_A   = 8;
  localparam int K_COIN_B   = 9;
  localparam int K_LEFT2    = 10;
  localparam int K_RIGHT2   = 11;
  localparam int K_FIRE2    = 12;
  localparam int K_TEST     = 13;

  // Joystick word layout (same for both players).
  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  // Switch byte bit positions (all active low).
  localparam int SW1_RIGHT  = 0;
  localparam int SW1_LEFT   = 1;
  localparam int SW1_FIRE   = 4;
  localparam int SW1_START1 = 5;
  localparam int SW1_START2 = 6;
  localparam int SW1_TEST   = 7;
  localparam int SW2_RIGHT  = 0;
  localparam int SW2_LEFT   = 1;
  localparam int SW2_FIRE   = 4;
  localparam int SW2_COIN   = 5;

  // Merged (key OR joystick) requests, active high.
  typedef struct packed {
    logic test;
    logic start2;
    logic start1;
    logic fire1;
    logic left1;
    logic right1;
    logic coin;
    logic fire2;
    logic left2;
    logic right2;
  } ctrl_t;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_st_t;

  function automatic logic [KEY_N-1:0] key_match(input logic [8:0] code);
    logic [KEY_N-1:0] m;
    m = '0;
    m[K_LEFT1]    = (code[7:0] == SC_LEFT1[7:0]);
    m[K_RIGHT1]   = (code[7:0] == SC_RIGHT1[7:0]);
    m[K_FIRE1_A]  = (code == SC_FIRE1_A);
    m[K_FIRE1_B]  = (code == SC_FIRE1_B);
    m[K_START1_A] = (code == SC_START1_A);
    m[K_START1_B] = (code == SC_START1_B);
    m[K_START2_A] = (code == SC_START2_A);
    m[K_START2_B] = (code == SC_START2_B);
    m[K_COIN_A]   = (code == SC_COIN_A);
    m[K_COIN_B]   = (code == SC_COIN_B);
    m[K_LEFT2]    = (code == SC_LEFT2);
    m[K_RIGHT2]   = (code == SC_RIGHT2);
    m[K_FIRE2]    = (code == SC_FIRE2);
    m[K_TEST]     = (code == SC_TEST);
    return m;
  endfunction

endpackage

// File: rtl/mario_input_2way.sv
// mario_input_2way
// Left/right resolver for one player: when both directions are held the
// most recently pressed one wins; a simultaneous press resolves to left.
// Ports:
//   clk_sys, reset      clock, asynchronous active-high reset
//   left, right         stage-1 (registered) direction requests
//   left_res, right_res resolved directions (combinational)
module mario_input_2way
  import mario_input_pkg::*;
(
  input  logic clk_sys,
  input  logic reset,
  input  logic left,
  input  logic right,
  output logic left_res,
  output logic right_res
);

  logic left_prev_reg;
  logic right_prev_reg;
  logic last_left_reg;   // 1: left was pressed last, 0: right
  logic last_left_next;
  logic rise_left;
  logic rise_right;
  logic both_held;

  assign rise_left  = left & ~left_prev_reg;
  assign rise_right = right & ~right_prev_reg;
  assign both_held  = left & right;

  // The current cycle's press must already count, so the output uses the
  // next value of the history rather than the registered one.
  always_comb begin
    last_left_next = last_left_reg;
    if (rise_left) begin
      last_left_next = 1'b1;
    end else if (rise_right) begin
      last_left_next = 1'b0;
    end
  end

  assign left_res  = both_held ? last_left_next : left;
  assign right_res = both_held ? ~last_left_next : right;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      left_prev_reg  <= 1'b0;
      right_prev_reg <= 1'b0;
      last_left_reg  <= 1'b0;
    end else begin
      left_prev_reg  <= left;
      right_prev_reg <= right;
      last_left_reg  <= last_left_next;
    end
  end

endmodule

// File: rtl/mario_input_ctrl.sv
// mario_input_ctrl
// Player-input front end feeding the game's switch ports. PS/2 key events
// and both joystick words are merged, left/right conflicts are resolved per
// player, and coin requests become fixed-width, rate-limited pulses.
// Ports:
//   clk_sys      system clock (24 MHz)
//   reset        asynchronous, active high
//   ps2_key      [10] event toggle, [9] pressed, [8:0] extended scancode
//   joy_0/joy_1  joystick words: [0] R, [1] L, [4] fire, [5] st1, [6] st2, [7] coin
//   o_sw1        {~test, ~start2, ~start1, ~fire1, 1, 1, ~left1, ~right1}
//   o_sw2        {1, 1, ~coin, ~fire2, 1, 1, ~left2, ~right2}
//   o_coin_busy  high while a coin pulse or its lockout gap is in progress
// Joystick changes appear at the outputs 2 cycles later, PS/2 events 3.
module mario_input_ctrl
  import mario_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 2400000,
  parameter int COIN_GAP_CYC   = 2400000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  output logic [7:0]  o_sw1,
  output logic [7:0]  o_sw2,
  output logic        o_coin_busy
);

  localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYC - 1);

  // ---------------- PS/2 decode ----------------
  logic             toggle_prev_reg;
  logic             key_evt;
  logic [KEY_N-1:0] key_hit;
  logic [KEY_N-1:0] key_mask;
  logic [KEY_N-1:0] key_reg;

  assign key_evt  = ps2_key[10] ^ toggle_prev_reg;
  assign key_hit  = key_match(ps2_key[8:0]);
  assign key_mask = key_evt ? key_hit : '0;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      toggle_prev_reg <= 1'b0;
      key_reg         <= '0;
    end else begin
      toggle_prev_reg <= ps2_key[10];
      key_reg         <= (key_reg & ~key_mask) | (key_mask & {KEY_N{ps2_key[9]}});
    end
  end

  // ---------------- merge (stage 1) ----------------
  ctrl_t merged;
  ctrl_t s1_reg;

  always_comb begin
    merged        = '0;
    merged.right1 = key_reg[K_RIGHT1] | joy_0[JOY_RIGHT];
    merged.left1  = key_reg[K_LEFT1]  | joy_0[JOY_LEFT];
    merged.fire1  = key_reg[K_FIRE1_A] | key_reg[K_FIRE1_B] | joy_0[JOY_FIRE];
    merged.start1 = key_reg[K_START1_A] | key_reg[K_START1_B]
                  | joy_0[JOY_START1] | joy_1[JOY_START1];
    merged.start2 = key_reg[K_START2_A] | key_reg[K_START2_B]
                  | joy_0[JOY_START2] | joy_1[JOY_START2];
    merged.test   = key_reg[K_TEST];
    merged.coin   = key_reg[K_COIN_A] | key_reg[K_COIN_B]
                  | joy_0[JOY_COIN] | joy_1[JOY_COIN];
    merged.right2 = key_reg[K_RIGHT2] | joy_1[JOY_RIGHT];
    merged.left2  = key_reg[K_LEFT2]  | joy_1[JOY_LEFT];
    merged.fire2  = key_reg[K_FIRE2]  | joy_1[JOY_FIRE];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_reg <= '0;
    end else begin
      s1_reg <= merged;
    end
  end

  // ---------------- SOCD per player ----------------
  logic left1_res, right1_res, left2_res, right2_res;

  mario_input_2way u_socd_p1 (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .left      (s1_reg.left1),
    .right     (s1_reg.right1),
    .left_res  (left1_res),
    .right_res (right1_res)
  );

  mario_input_2way u_socd_p2 (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .left      (s1_reg.left2),
    .right     (s1_reg.right2),
    .left_res  (left2_res),
    .right_res (right2_res)
  );

  // ---------------- output stage ----------------
  logic [7:0] sw1_reg, sw1_next;
  logic [7:0] sw2_reg, sw2_next;

  always_comb begin
    sw1_next             = 8'hFF;
    sw1_next[SW1_RIGHT]  = ~right1_res;
    sw1_next[SW1_LEFT]   = ~left1_res;
    sw1_next[SW1_FIRE]   = ~s1_reg.fire1;
    sw1_next[SW1_START1] = ~s1_reg.start1;
    sw1_next[SW1_START2] = ~s1_reg.start2;
    sw1_next[SW1_TEST]   = ~s1_reg.test;
    sw2_next             = 8'hFF;
    sw2_next[SW2_RIGHT]  = ~right2_res;
    sw2_next[SW2_LEFT]   = ~left2_res;
    sw2_next[SW2_FIRE]   = ~s1_reg.fire2;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sw1_reg <= 8'hFF;
      sw2_reg <= 8'hFF;
    end else begin
      sw1_reg <= sw1_next;
      sw2_reg <= sw2_next;
    end
  end

  // ---------------- coin shaper ----------------
  coin_st_t         coin_st_reg, coin_st_next;
  logic [CNT_W-1:0] coin_cnt_reg, coin_cnt_next;
  logic             pend_reg, pend_next;
  logic             coin_prev_reg;
  logic             coin_rise;

  assign coin_rise = s1_reg.coin & ~coin_prev_reg;

  always_comb begin
    coin_st_next  = coin_st_reg;
    coin_cnt_next = coin_cnt_reg;
    pend_next     = pend_reg;
    case (coin_st_reg)
      COIN_IDLE: begin
        if (coin_rise) begin
          coin_st_next  = COIN_PULSE;
          coin_cnt_next = PULSE_LOAD;
        end
      end
      COIN_PULSE: begin
        if (coin_rise) begin
          pend_next = 1'b1;
        end
        if (coin_cnt_reg == '0) begin
          coin_st_next  = COIN_GAP;
          coin_cnt_next = GAP_LOAD;
        end else begin
          coin_cnt_next = coin_cnt_reg - 1'b1;
        end
      end
      COIN_GAP: begin
        if (coin_cnt_reg == '0) begin
          // An edge on the very last gap cycle still counts as pending.
          if (pend_reg | coin_rise) begin
            coin_st_next  = COIN_PULSE;
            coin_cnt_next = PULSE_LOAD;
            pend_next     = 1'b0;
          end else begin
            coin_st_next  = COIN_IDLE;
          end
        end else begin
          coin_cnt_next = coin_cnt_reg - 1'b1;
          if (coin_rise) begin
            pend_next = 1'b1;
          end
        end
      end
      default: begin
        coin_st_next  = COIN_IDLE;
        coin_cnt_next = '0;
        pend_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      coin_st_reg   <= COIN_IDLE;
      coin_cnt_reg  <= '0;
      pend_reg      <= 1'b0;
      coin_prev_reg <= 1'b0;
    end else begin
      coin_st_reg   <= coin_st_next;
      coin_cnt_reg  <= coin_cnt_next;
      pend_reg      <= pend_next;
      coin_prev_reg <= s1_reg.coin;
    end
  end

  // The coin bit comes straight from the state register so that reset
  // releases it without waiting for a clock.
  always_comb begin
    o_sw1           = sw1_reg;
    o_sw2           = sw2_reg;
    o_sw2[SW2_COIN] = (coin_st_reg != COIN_PULSE);
  end

  assign o_coin_busy = (coin_st_reg != COIN_IDLE);

  logic unused_joy;
  assign unused_joy = ^{joy_0[15:8], joy_0[3:2], joy_1[15:8], joy_1[3:2]};

endmodule
